// File: rtl/bnn_param_loader.sv
// Streams CHAIN_BITS parameter bits MSB-first from a byte stream into a serial neuron chain; the minimum load time is 1+NBYTES+CHAIN_BITS cycles.
// Backpressure: in_ready is high only while waiting for a byte, and the chain holds (setup=0) while in_valid is low.
module bnn_param_loader #(
   parameter int NEURONS   = 4,
   parameter int INPUTS    = 8,
   parameter int BIAS_BITS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       setup,
   output logic       param_out,
   output logic       busy,
   output logic       done
);

   localparam int CHAIN_BITS = NEURONS * (INPUTS + BIAS_BITS);
   localparam int NBYTES     = (CHAIN_BITS + 7) / 8;
   localparam int CW_RAW     = $clog2(CHAIN_BITS + 1);
   localparam int CW         = (CW_RAW < 6) ? 6 : CW_RAW;

   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

   state_t          state, state_nxt;
   logic [7:0]      byte_reg;
   logic [2:0]      bit_idx;
   logic [CW-1:0]   bit_cnt;
   logic            done_reg;

   logic            load_byte;
   logic            shift_en;
   logic            clr_cnt;
   logic            done_set;
   logic            last_chain_bit;

   // The final byte may be partial; the chain count ends SHIFT before its low bits go out.
   assign last_chain_bit = (bit_cnt == CW'(CHAIN_BITS - 1));

   always_comb begin
      state_nxt = state;
      load_byte = 1'b0;
      shift_en  = 1'b0;
      clr_cnt   = 1'b0;
      done_set  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = FETCH;
               clr_cnt   = 1'b1;
            end
         end
         FETCH: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (in_valid) begin
               state_nxt = SHIFT;
               load_byte = 1'b1;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               shift_en = 1'b1;
               if (last_chain_bit) begin
                  state_nxt = DONE;
                  done_set  = 1'b1;
               end else if (bit_idx == 3'd7) begin
                  state_nxt = FETCH;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         byte_reg <= '0;
         bit_idx  <= '0;
         bit_cnt  <= '0;
         done_reg <= 1'b0;
      end else begin
         state <= state_nxt;
         if (clr_cnt) begin
            bit_cnt  <= '0;
            done_reg <= 1'b0;
         end
         if (done_set) begin
            done_reg <= 1'b1;
         end
         if (load_byte) begin
            byte_reg <= in_data;
            bit_idx  <= '0;
         end else if (shift_en) begin
            byte_reg <= {byte_reg[6:0], 1'b0};
            bit_idx  <= bit_idx + 3'd1;
            bit_cnt  <= bit_cnt + CW'(1);
         end
      end
   end

   assign in_ready  = (state == FETCH);
   assign setup     = (state == SHIFT);
   assign param_out = (state == SHIFT) & byte_reg[7];
   assign busy      = (state == FETCH) | (state == SHIFT);
   assign done      = done_reg;

endmodule
